// File: rtl/instr_fetch_tracked_pkg.sv
// Shared types for the instruction fetch stage: addresses, raw words and
// the {raw, pc} pair that goes to decode, plus the response-path mode.
// No ports; imported by the interface, the tracker and the top.
package instr_fetch_tracked_pkg;

  localparam int ADDR_W = 32;
  localparam int RAW_W  = 32;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [RAW_W-1:0]  raw_t;

  typedef struct packed {
    raw_t  raw;
    addr_t pc;
  } fetched_instr_t;

  // What the response channel is doing this cycle.
  typedef enum logic [1:0] {
    MODE_IDLE  = 2'd0,  // nothing owed: responses are not accepted
    MODE_LIVE  = 2'd1,  // responses pair with tracker head and go to decode
    MODE_DROP  = 2'd2,  // responses owed for flushed requests are swallowed
    MODE_FLUSH = 2'd3   // flush pulse: swallow anything, no issue
  } resp_mode_e;

endpackage

// File: rtl/instr_fetch_tracked_if.sv
// Handshake bundle around the fetch stage: PC in, fetched pair out,
// memory request out, memory response in, plus flush and idle.
// Latency n/a (wires only); slave = fetch stage, master = its environment.
interface instr_fetch_tracked_if;
  import instr_fetch_tracked_pkg::*;

  logic           pc_vld;
  logic           pc_rdy;
  addr_t          pc_dat;

  logic           fetched_vld;
  logic           fetched_rdy;
  fetched_instr_t fetched_dat;

  logic           mem_req_vld;
  logic           mem_req_rdy;
  addr_t          mem_req_dat;

  logic           mem_resp_vld;
  logic           mem_resp_rdy;
  raw_t           mem_resp_dat;

  logic           flush;
  logic           idle;

  modport slave (
    input  pc_vld, pc_dat, fetched_rdy, mem_req_rdy,
           mem_resp_vld, mem_resp_dat, flush,
    output pc_rdy, fetched_vld, fetched_dat, mem_req_vld, mem_req_dat,
           mem_resp_rdy, idle
  );

  modport master (
    output pc_vld, pc_dat, fetched_rdy, mem_req_rdy,
           mem_resp_vld, mem_resp_dat, flush,
    input  pc_rdy, fetched_vld, fetched_dat, mem_req_vld, mem_req_dat,
           mem_resp_rdy, idle
  );

endinterface

// File: rtl/instr_fetch_tracked_fetch_tracker.sv
// Clearable circular FIFO of issued PCs; head is the PC of the oldest live request.
// Latency: head/count are registered, push/pop/clear take effect next cycle.
// No internal backpressure: caller never pushes when full nor pops when empty.
// Ports: i_clk, i_rst_n (async low), i_push/i_push_dat, i_pop, i_clr, o_count, o_head.
module instr_fetch_tracked_fetch_tracker
  import instr_fetch_tracked_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_push,
  input  addr_t                        i_push_dat,
  input  logic                         i_pop,
  input  logic                         i_clr,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output addr_t                        o_head
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  addr_t          r_mem [DEPTH];
  logic [PW-1:0]  r_wr_ptr;
  logic [PW-1:0]  r_rd_ptr;
  logic [CW-1:0]  r_count;

  // Explicit wrap so non-power-of-2 depths never index past DEPTH-1.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (i_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end

  // Storage needs no reset: count gates every read of it.
  always_ff @(posedge i_clk) begin
    if (i_push && !i_clr) r_mem[r_wr_ptr] <= i_push_dat;
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/instr_fetch_tracked.sv
// Fetch stage: issues PCs to instruction memory, pairs in-order responses with
// their PCs (0 added latency), and swallows responses owed across a flush.
// Backpressure: pc stalls on mem_req_rdy / capacity / flush; mem_resp stalls on fetched_rdy.
// Ports: i_clk, i_rst_n (async low), if_bus (slave), o_live_cnt/o_drop_cnt observation.
module instr_fetch_tracked
  import instr_fetch_tracked_pkg::*;
#(
  parameter int MAX_INFLIGHT = 2
) (
  input  logic                                i_clk,
  input  logic                                i_rst_n,
  instr_fetch_tracked_if.slave                if_bus,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0]   o_live_cnt,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0]   o_drop_cnt
);

  localparam int CW = $clog2(MAX_INFLIGHT + 1);

  logic [CW-1:0]  w_live_cnt;
  logic [CW-1:0]  r_drop_cnt;
  logic [CW-1:0]  w_drop_nxt;
  logic [CW-1:0]  w_owed_sum;
  logic [CW:0]    w_owed;
  logic           w_room;
  logic           w_issue_ok;
  logic           w_issue_fire;
  logic           w_resp_fire;
  logic           w_pop;
  addr_t          w_head;
  resp_mode_e     w_mode;

  // Capacity from registered counts only, so a response this cycle never
  // opens a slot combinationally (no resp->req path).
  assign w_owed     = {1'b0, w_live_cnt} + {1'b0, r_drop_cnt};
  assign w_room     = w_owed < (CW+1)'(MAX_INFLIGHT);
  assign w_issue_ok = !if_bus.flush && w_room;

  assign if_bus.mem_req_vld = if_bus.pc_vld && w_issue_ok;
  assign if_bus.pc_rdy      = if_bus.mem_req_rdy && w_issue_ok;
  assign if_bus.mem_req_dat = if_bus.pc_dat;

  assign w_issue_fire = if_bus.mem_req_vld && if_bus.mem_req_rdy;
  assign w_resp_fire  = if_bus.mem_resp_vld && if_bus.mem_resp_rdy;

  // Drops must be drained before live responses: memory is in order, so
  // everything owed for flushed requests arrives first.
  always_comb begin
    w_mode = MODE_IDLE;
    if (if_bus.flush)           w_mode = MODE_FLUSH;
    else if (r_drop_cnt != '0)  w_mode = MODE_DROP;
    else if (w_live_cnt != '0)  w_mode = MODE_LIVE;
  end

  always_comb begin
    if_bus.fetched_vld  = 1'b0;
    if_bus.mem_resp_rdy = 1'b0;
    case (w_mode)
      MODE_FLUSH,
      MODE_DROP: if_bus.mem_resp_rdy = 1'b1;
      MODE_LIVE: begin
        if_bus.fetched_vld  = if_bus.mem_resp_vld;
        if_bus.mem_resp_rdy = if_bus.fetched_rdy;
      end
      default: ;  // unexpected response is left unaccepted
    endcase
  end

  assign if_bus.fetched_dat = '{raw: if_bus.mem_resp_dat, pc: w_head};
  assign w_pop = w_resp_fire && (w_mode == MODE_LIVE);

  // Live requests become owed drops on flush; a response accepted in the
  // flush cycle settles one of them immediately.
  assign w_owed_sum = r_drop_cnt + w_live_cnt;

  always_comb begin
    w_drop_nxt = r_drop_cnt;
    case (w_mode)
      MODE_FLUSH: begin
        if (w_resp_fire && w_owed_sum != '0) w_drop_nxt = w_owed_sum - CW'(1);
        else                                 w_drop_nxt = w_owed_sum;
      end
      MODE_DROP: if (w_resp_fire) w_drop_nxt = r_drop_cnt - CW'(1);
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_drop_cnt <= '0;
    else          r_drop_cnt <= w_drop_nxt;
  end

  instr_fetch_tracked_fetch_tracker #(
    .DEPTH (MAX_INFLIGHT)
  ) u_tracker (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_push     (w_issue_fire),
    .i_push_dat (if_bus.pc_dat),
    .i_pop      (w_pop),
    .i_clr      (if_bus.flush),
    .o_count    (w_live_cnt),
    .o_head     (w_head)
  );

  assign if_bus.idle = (w_live_cnt == '0) && (r_drop_cnt == '0);
  assign o_live_cnt  = w_live_cnt;
  assign o_drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_instr_fetch_tracked.sv
// Directed bench: a per-cycle vector table on a depth-2 stage (streaming,
// backpressure, flushes, stalls) and hand sequences on a depth-3 stage
// (capacity, drain, pointer wrap) plus an asynchronous reset mid-stream.
module tb_instr_fetch_tracked;
  import instr_fetch_tracked_pkg::*;

  localparam logic [31:0] MEM_TAG = 32'h1000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  instr_fetch_tracked_if if2 ();
  instr_fetch_tracked_if if3 ();
  logic [1:0] live2, drop2, live3, drop3;

  instr_fetch_tracked #(.MAX_INFLIGHT(2)) u_dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .if_bus(if2), .o_live_cnt(live2), .o_drop_cnt(drop2));
  instr_fetch_tracked #(.MAX_INFLIGHT(3)) u_dut3 (
    .i_clk(clk), .i_rst_n(rst_n), .if_bus(if3), .o_live_cnt(live3), .o_drop_cnt(drop3));

  typedef struct {
    logic pv; logic [31:0] pa; logic qr; logic rv; logic [31:0] ra; logic fr; logic fl;
    logic e_pr; logic e_qv; logic e_rr; logic e_fv; logic [31:0] e_fpc;
    logic [1:0] e_live; logic [1:0] e_drop; logic e_idle;
  } vec_t;
  vec_t vq[$];

  task automatic add(input logic pv, input logic [31:0] pa, input logic qr, input logic rv,
                     input logic [31:0] ra, input logic fr, input logic fl,
                     input logic e_pr, input logic e_qv, input logic e_rr, input logic e_fv,
                     input logic [31:0] e_fpc, input logic [1:0] e_live,
                     input logic [1:0] e_drop, input logic e_idle);
    vec_t v;
    v = '{pv, pa, qr, rv, ra, fr, fl, e_pr, e_qv, e_rr, e_fv, e_fpc, e_live, e_drop, e_idle};
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // A response with nothing owed is a protocol violation by the environment.
  always @(posedge clk) begin
    if (rst_n && if2.mem_resp_vld && !if2.flush && live2 == 0 && drop2 == 0) begin
      n_fail++; $display("FAIL protocol2: response with nothing in flight");
    end
    if (rst_n && if3.mem_resp_vld && !if3.flush && live3 == 0 && drop3 == 0) begin
      n_fail++; $display("FAIL protocol3: response with nothing in flight");
    end
  end

  initial begin
    {if2.pc_vld, if2.mem_resp_vld, if2.flush} = '0;
    if2.pc_dat = '0; if2.mem_resp_dat = '0; if2.mem_req_rdy = 1'b1; if2.fetched_rdy = 1'b1;
    {if3.pc_vld, if3.mem_resp_vld, if3.flush} = '0;
    if3.pc_dat = '0; if3.mem_resp_dat = '0; if3.mem_req_rdy = 1'b1; if3.fetched_rdy = 1'b1;

    //   pv  pa      qr rv ra      fr fl | pr qv rr fv fpc     live drop idle
    // streaming, 1-cycle memory
    add(1, 32'h0,   1, 0, 32'h0,   1, 0,   1, 1, 0, 0, 32'h0,   0, 0, 1);
    add(1, 32'h4,   1, 1, 32'h0,   1, 0,   1, 1, 1, 1, 32'h0,   1, 0, 0);
    add(1, 32'h8,   1, 1, 32'h4,   1, 0,   1, 1, 1, 1, 32'h4,   1, 0, 0);
    add(1, 32'hC,   1, 1, 32'h8,   1, 0,   1, 1, 1, 1, 32'h8,   1, 0, 0);
    add(0, 32'h0,   1, 1, 32'hC,   1, 0,   1, 0, 1, 1, 32'hC,   1, 0, 0);
    add(0, 32'h0,   1, 0, 32'h0,   1, 0,   1, 0, 0, 0, 32'h0,   0, 0, 1);
    // backpressure: 2 outstanding, decode stalled 5 cycles
    add(1, 32'h20,  1, 0, 32'h0,   0, 0,   1, 1, 0, 0, 32'h0,   0, 0, 1);
    add(1, 32'h24,  1, 0, 32'h0,   0, 0,   1, 1, 0, 0, 32'h0,   1, 0, 0);
    for (int k = 0; k < 5; k++)
      add(1, 32'h28, 1, 1, 32'h20, 0, 0,   0, 0, 0, 1, 32'h20,  2, 0, 0);
    add(1, 32'h28,  1, 1, 32'h20,  1, 0,   0, 0, 1, 1, 32'h20,  2, 0, 0);
    add(1, 32'h28,  1, 1, 32'h24,  1, 0,   1, 1, 1, 1, 32'h24,  1, 0, 0);
    add(0, 32'h0,   1, 1, 32'h28,  1, 0,   1, 0, 1, 1, 32'h28,  1, 0, 0);
    // flush with 2 in flight, slow memory
    add(1, 32'h100, 1, 0, 32'h0,   1, 0,   1, 1, 0, 0, 32'h0,   0, 0, 1);
    add(1, 32'h104, 1, 0, 32'h0,   1, 0,   1, 1, 1, 0, 32'h0,   1, 0, 0);
    add(1, 32'h200, 1, 0, 32'h0,   1, 1,   0, 0, 1, 0, 32'h0,   2, 0, 0);
    add(1, 32'h200, 1, 1, 32'h100, 0, 0,   0, 0, 1, 0, 32'h0,   0, 2, 0);
    add(1, 32'h200, 1, 1, 32'h104, 1, 0,   1, 1, 1, 0, 32'h0,   0, 1, 0);
    add(0, 32'h0,   1, 0, 32'h0,   1, 0,   1, 0, 1, 0, 32'h0,   1, 0, 0);
    add(0, 32'h0,   1, 1, 32'h200, 1, 0,   1, 0, 1, 1, 32'h200, 1, 0, 0);
    add(0, 32'h0,   1, 0, 32'h0,   1, 0,   1, 0, 0, 0, 32'h0,   0, 0, 1);
    // flush coinciding with the response for 0x100
    add(1, 32'h100, 1, 0, 32'h0,   1, 0,   1, 1, 0, 0, 32'h0,   0, 0, 1);
    add(1, 32'h104, 1, 0, 32'h0,   1, 0,   1, 1, 1, 0, 32'h0,   1, 0, 0);
    add(0, 32'h0,   1, 1, 32'h100, 1, 1,   0, 0, 1, 0, 32'h0,   2, 0, 0);
    add(0, 32'h0,   1, 0, 32'h0,   1, 0,   1, 0, 1, 0, 32'h0,   0, 1, 0);
    add(0, 32'h0,   1, 1, 32'h104, 1, 0,   1, 0, 1, 0, 32'h0,   0, 1, 0);
    add(0, 32'h0,   1, 0, 32'h0,   1, 0,   1, 0, 0, 0, 32'h0,   0, 0, 1);
    // flush with nothing in flight, then a memory-side stall
    add(1, 32'h300, 1, 0, 32'h0,   1, 1,   0, 0, 1, 0, 32'h0,   0, 0, 1);
    add(0, 32'h0,   1, 0, 32'h0,   1, 0,   1, 0, 0, 0, 32'h0,   0, 0, 1);
    add(1, 32'h500, 0, 0, 32'h0,   1, 0,   0, 1, 0, 0, 32'h0,   0, 0, 1);
    add(0, 32'h0,   1, 0, 32'h0,   1, 0,   1, 0, 0, 0, 32'h0,   0, 0, 1);

    // reset state
    #12;
    chk("rst idle2", if2.idle, 1);       chk("rst fvld2", if2.fetched_vld, 0);
    chk("rst rrdy2", if2.mem_resp_rdy, 0); chk("rst live2", live2, 0);
    chk("rst drop2", drop2, 0);          chk("rst idle3", if3.idle, 1);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      if2.pc_vld = vq[i].pv; if2.pc_dat = vq[i].pa; if2.mem_req_rdy = vq[i].qr;
      if2.mem_resp_vld = vq[i].rv; if2.mem_resp_dat = MEM_TAG | vq[i].ra;
      if2.fetched_rdy = vq[i].fr; if2.flush = vq[i].fl;
      #2;
      chk($sformatf("row%0d pc_rdy", i), if2.pc_rdy, vq[i].e_pr);
      chk($sformatf("row%0d req_vld", i), if2.mem_req_vld, vq[i].e_qv);
      chk($sformatf("row%0d resp_rdy", i), if2.mem_resp_rdy, vq[i].e_rr);
      chk($sformatf("row%0d fet_vld", i), if2.fetched_vld, vq[i].e_fv);
      chk($sformatf("row%0d live", i), live2, vq[i].e_live);
      chk($sformatf("row%0d drop", i), drop2, vq[i].e_drop);
      chk($sformatf("row%0d idle", i), if2.idle, vq[i].e_idle);
      if (vq[i].e_qv) chk($sformatf("row%0d req_dat", i), if2.mem_req_dat, vq[i].pa);
      if (vq[i].e_fv) begin
        chk($sformatf("row%0d fet_pc", i), if2.fetched_dat.pc, vq[i].e_fpc);
        chk($sformatf("row%0d fet_raw", i), if2.fetched_dat.raw, MEM_TAG | vq[i].e_fpc);
      end
    end
    @(negedge clk);
    {if2.pc_vld, if2.mem_resp_vld, if2.flush} = '0;

    // capacity on depth 3: memory holds every response
    begin
      int n_issued;
      n_issued = 0;
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        if3.pc_vld = 1'b1; if3.pc_dat = 32'h40 + 32'(4 * n_issued);
        #2;
        if (if3.pc_vld && if3.pc_rdy) n_issued++;
      end
      chk("cap issued", n_issued, 3);
      chk("cap pc_rdy", if3.pc_rdy, 0);
      chk("cap live", live3, 3);
    end
    @(negedge clk); if3.pc_vld = 1'b0; if3.flush = 1'b1;
    #2 chk("cap flush rrdy", if3.mem_resp_rdy, 1);
    @(negedge clk); if3.flush = 1'b0;
    #2 chk("cap drop", drop3, 3); chk("cap live0", live3, 0); chk("cap idle0", if3.idle, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); if3.mem_resp_vld = 1'b1; if3.mem_resp_dat = MEM_TAG | (32'h40 + 32'(4 * k));
      #2 chk($sformatf("drain%0d idle", k), if3.idle, 0);
      chk($sformatf("drain%0d fvld", k), if3.fetched_vld, 0);
      chk($sformatf("drain%0d rrdy", k), if3.mem_resp_rdy, 1);
    end
    @(negedge clk); if3.mem_resp_vld = 1'b0;
    #2 chk("drain idle", if3.idle, 1); chk("drain drop", drop3, 0);

    // pointer wrap on depth 3: 3 issues, 2 pops, 2 issues, 3 pops
    for (int k = 0; k < 5; k++) begin
      if (k == 3) begin
        for (int j = 0; j < 2; j++) begin
          @(negedge clk); if3.pc_vld = 1'b0;
          if3.mem_resp_vld = 1'b1; if3.mem_resp_dat = MEM_TAG | (32'h60 + 32'(4 * j));
          #2 chk($sformatf("wrapA%0d fvld", j), if3.fetched_vld, 1);
          chk($sformatf("wrapA%0d pc", j), if3.fetched_dat.pc, 32'h60 + 32'(4 * j));
        end
      end
      @(negedge clk); if3.mem_resp_vld = 1'b0; if3.pc_vld = 1'b1; if3.pc_dat = 32'h60 + 32'(4 * k);
      #2 chk($sformatf("wrap issue%0d", k), if3.pc_rdy, 1);
    end
    for (int j = 2; j < 5; j++) begin
      @(negedge clk); if3.pc_vld = 1'b0;
      if3.mem_resp_vld = 1'b1; if3.mem_resp_dat = MEM_TAG | (32'h60 + 32'(4 * j));
      #2 chk($sformatf("wrapB%0d pc", j), if3.fetched_dat.pc, 32'h60 + 32'(4 * j));
      chk($sformatf("wrapB%0d raw", j), if3.fetched_dat.raw, MEM_TAG | (32'h60 + 32'(4 * j)));
    end
    @(negedge clk); if3.mem_resp_vld = 1'b0;
    #2 chk("wrap idle", if3.idle, 1);

    // asynchronous reset mid-stream on depth 2
    @(negedge clk); if2.pc_vld = 1'b1; if2.pc_dat = 32'h400; if2.fetched_rdy = 1'b0;
    @(negedge clk); if2.pc_dat = 32'h404;
    @(negedge clk); if2.pc_vld = 1'b0; if2.mem_resp_vld = 1'b1; if2.mem_resp_dat = MEM_TAG | 32'h400;
    #2 chk("arst pre fvld", if2.fetched_vld, 1); chk("arst pre live", live2, 2);
    #1 rst_n = 1'b0;
    #1 chk("arst fvld", if2.fetched_vld, 0); chk("arst idle", if2.idle, 1);
    chk("arst live", live2, 0); chk("arst drop", drop2, 0);
    chk("arst rrdy", if2.mem_resp_rdy, 0);
    @(negedge clk); if2.mem_resp_vld = 1'b0; if2.fetched_rdy = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    #2 chk("arst post idle", if2.idle, 1); chk("arst post pc_rdy", if2.pc_rdy, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
